// File: rtl/neurocore_pkg.sv
// Shared definitions for the neurocore UART receive path: data width,
// receiver state encoding and the even-parity helper.
package neurocore_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_PARITY    = 3'd3,
    UART_STOP      = 3'd4,
    UART_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 so an
// idle line does not look like a start edge when reset is released.
module uart_rx_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: d -> meta -> q.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit, with a single-entry
// holding register and valid/ready hand-off.
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit after
// data bit 7 (8E1). Without it the frame is 8N1 and parity_err is tied low.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// UART_IDLE      | line idle, waiting for a high-to-low edge
// UART_START     | half a bit in, confirming the start bit is still low
// UART_DATA      | sampling 8 data bits at bit centres
// UART_PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// UART_STOP      | sampling the stop bit, accept or flag a framing error
// UART_WAIT_IDLE | bad stop bit seen, waiting for the line to return high
module uart_rx
  import neurocore_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be in 4..65535");
  end

  // Timers are down-counters loaded with (interval - 1) and acted on at zero.
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rxd_s;
  logic                      rxd_prev;
  uart_rx_state_t            state;
  logic [15:0]               cnt;
  logic                      tick;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      accept;
  logic                      stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad;
  logic                      par_mismatch;
`endif

  uart_rx_sync u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (RXD),
    .q     (rxd_s)
  );

  assign tick = (cnt == 16'd0);
  assign busy = (state != UART_IDLE);

  // Frame sequencing: start detection, bit-centre sampling and stop handling.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= UART_IDLE;
      cnt       <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
      rxd_prev  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      rxd_prev <= rxd_s;
      case (state)
        UART_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            state   <= UART_START;
            cnt     <= HALF_LOAD;
            bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        UART_START: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (!rxd_s) begin
            state <= UART_DATA;
            cnt   <= BIT_LOAD;
          end else begin
            // Glitch shorter than half a bit: drop it silently.
            state <= UART_IDLE;
          end
        end
        UART_DATA: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
            cnt       <= BIT_LOAD;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= UART_PARITY;
`else
              state <= UART_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        UART_PARITY: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            par_bad <= par_mismatch;
            cnt     <= BIT_LOAD;
            state   <= UART_STOP;
          end
        end
`endif
        UART_STOP: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (rxd_s) begin
            state <= UART_IDLE;
          end else begin
            state <= UART_WAIT_IDLE;
          end
        end
        UART_WAIT_IDLE: begin
          // A held-low break stays here so it raises only one frame_err.
          if (rxd_s) begin
            state <= UART_IDLE;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

  // Frame verdicts at the stop (and parity) sample points.
  always_comb begin
    accept   = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mismatch = 1'b0;
    if (state == UART_PARITY && tick) begin
      par_mismatch = (rxd_s != even_parity(shift_reg));
    end
    // A parity failure already reported the frame; the stop bit only decides
    // where to go next, so the error pulses stay exclusive.
    if (state == UART_STOP && tick && !par_bad) begin
      accept   = rxd_s;
      stop_bad = !rxd_s;
    end
`else
    if (state == UART_STOP && tick) begin
      accept   = rxd_s;
      stop_bad = !rxd_s;
    end
`endif
  end

  // Holding register hand-off plus frame/overrun error pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= accept && rx_valid && !rx_ready;
      if (accept && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, raised at the parity sample point.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_mismatch;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16: a frame table checked through a
// byte scoreboard and error-pulse counters, plus hand-written sequences for
// false start, overrun, mid-frame reset and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RXD;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RXD         (RXD),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail = 0;
  int         fe_cnt = 0;
  int         oe_cnt = 0;
  int         pe_cnt = 0;
  int         valid_cycles = 0;
  int         delivered = 0;
  int         fe0, oe0, pe0, v0, d0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       prev_valid = 1'b0;
  logic       prev_pop = 1'b0;
  logic [7:0] prev_data = 8'd0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    int         exp_del;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    if (!stop) begin
      repeat (64) @(posedge CLK);
      #1;
    end
    RXD = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    fe0 = fe_cnt; oe0 = oe_cnt; pe0 = pe_cnt; v0 = valid_cycles; d0 = delivered;
  endtask

  // Output monitor: scoreboard pops on hand-off, pulse counting, stability.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_valid = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      if (prev_valid && !prev_pop && rx_valid)
        check("rx_data_stable", {24'd0, rx_data}, {24'd0, prev_data});
      if (rx_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (parity_err) pe_cnt++;
      if (frame_err || overrun_err || parity_err)
        check("err_exclusive", int'(frame_err) + int'(overrun_err) + int'(parity_err), 1);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
          delivered++;
        end
      end
      prev_valid = rx_valid;
      prev_pop   = rx_valid && rx_ready;
      prev_data  = rx_data;
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0, 1};
    vecs[1] = '{8'h00, 1'b1, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 0, 1};
    vecs[3] = '{8'h3C, 1'b0, 1, 0};
    vecs[4] = '{8'h5A, 1'b1, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 0, 1};

    RESET = 1'b1; RXD = 1'b1; rx_ready = 1'b1;
    #1;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun_err", overrun_err, 0);
    check("reset_parity_err", parity_err, 0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    for (int i = 0; i < 6; i++) begin
      snap();
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_delivered", i), delivered - d0, vecs[i].exp_del);
      check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, vecs[i].exp_del);
      check($sformatf("vec%0d_overrun", i), oe_cnt - oe0, 0);
    end

    // Short low glitch from idle.
    snap();
    RXD = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RXD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      @(posedge CLK);
      #1;
    end
    check("false_start_busy", busy, 0);
    repeat (2 * CPB) @(posedge CLK);
    #1;
    check("false_start_valid", valid_cycles - v0, 0);
    check("false_start_frame_err", fe_cnt - fe0, 0);

    // Overrun: second byte dropped while the first waits.
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("overrun_valid_held", rx_valid, 1);
    check("overrun_data_held", rx_data, 8'h11);
    check("overrun_pulses", oe_cnt - oe0, 1);
    check("overrun_none_popped", delivered - d0, 0);
    rx_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("overrun_popped", delivered - d0, 1);
    check("overrun_valid_cleared", rx_valid, 0);

    // Reset in the middle of data bit 3 of 0x96.
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    RXD = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    check("midframe_busy", busy, 1);
    RESET = 1'b1;
    RXD = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    check("after_reset_delivered", delivered - d0, 1);
    check("after_reset_frame_err", fe_cnt - fe0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x01 with wrong parity bit 0, then with correct parity bit 1.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i == 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    RXD = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    #1;
    check("parity_bad_pulse", pe_cnt - pe0, 1);
    check("parity_bad_frame_err", fe_cnt - fe0, 0);
    check("parity_bad_delivered", delivered - d0, 0);
    snap();
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    check("parity_good_delivered", delivered - d0, 1);
    check("parity_good_pulse", pe_cnt - pe0, 0);
    check("parity_total", pe_cnt, 1);
`else
    check("parity_total", pe_cnt, 0);
`endif

    repeat (20) @(posedge CLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
